hs_rr_collector: RTL



---
 rtl/hs_collector_pkg.sv | 20 ++
 rtl/hs_rr_arb.sv | 37 +++
 rtl/hs_rr_collector.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hs_collector_pkg.sv
// Shared types and helpers for the round-robin handshake collector.
// Holds the per-channel state encoding and the channel-tag width function.
package hs_collector_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    typedef enum logic [1:0] {
        CH_IDLE = ST_IDLE,
        CH_PEND = ST_PEND,
        CH_ACK  = ST_ACK
    } ch_state_t;

    // Tag width never collapses to zero bits, even for tiny channel counts.
    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hs_rr_arb.sv
// Combinational round-robin arbiter: first pending channel at or after ptr,
// wrapping at N-1 -> 0. Produces a one-hot grant, its index and a hit flag.
module hs_rr_arb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] pend,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         hit
);

    always_comb begin
        logic [W:0]   sum;
        logic [W-1:0] cand;
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            // ptr + k folded back into 0..N-1 without a modulo operator
            sum = {1'b0, ptr} + (W+1)'(k);
            if (sum >= (W+1)'(N)) begin
                sum = sum - (W+1)'(N);
            end
            cand = sum[W-1:0];
            if (!hit && pend[cand]) begin
                hit         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/hs_rr_collector.sv
// N-channel four-phase req/ack collector feeding a one-entry valid/ready slot.
// Optional sticky withdrawal flags (oErr) when HS_RR_COLLECTOR_ERR_EN is defined.
module hs_rr_collector
    import hs_collector_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int CH_NUM     = 4,
    localparam int CH_W       = tag_width(CH_NUM)
) (
    input  logic                         iClk,
    input  logic                         iRst,
    input  logic [CH_NUM-1:0]            iReq,
    input  logic [CH_NUM*DATA_WIDTH-1:0] iData,
    output logic [CH_NUM-1:0]            oAck,
`ifdef HS_RR_COLLECTOR_ERR_EN
    output logic [CH_NUM-1:0]            oErr,
`endif
    output logic                         oValid,
    input  logic                         iReady,
    output logic [DATA_WIDTH-1:0]        oData,
    output logic [CH_W-1:0]              oChId
);

    logic [CH_NUM-1:0]     pend;
    logic [CH_NUM-1:0]     pend_gated;
    logic [CH_NUM-1:0]     grant;
    logic [CH_W-1:0]       grant_idx;
    logic                  grant_any;
    logic                  slot_free;
    logic [CH_W-1:0]       rr_ptr_reg;
    logic [CH_W-1:0]       rr_ptr_next;
    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [CH_W-1:0]       ch_id_reg;

    // A pop and a push may share a cycle, so the slot is free when being drained.
    assign slot_free  = !valid_reg || iReady;
    assign pend_gated = slot_free ? pend : '0;

    hs_rr_arb #(
        .N (CH_NUM),
        .W (CH_W)
    ) u_arb (
        .pend  (pend_gated),
        .ptr   (rr_ptr_reg),
        .grant (grant),
        .idx   (grant_idx),
        .hit   (grant_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            ch_state_t state_reg;
            ch_state_t state_next;

            always_ff @(posedge iClk) begin
                if (iRst) begin
                    state_reg <= CH_IDLE;
                end else begin
                    state_reg <= state_next;
                end
            end

            // A grant wins over a same-cycle withdrawal: the word is already captured.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    CH_IDLE: if (iReq[gi]) state_next = CH_PEND;
                    CH_PEND: begin
                        if (grant[gi]) begin
                            state_next = CH_ACK;
                        end else if (!iReq[gi]) begin
                            state_next = CH_IDLE;
                        end
                    end
                    CH_ACK:  if (!iReq[gi]) state_next = CH_IDLE;
                    default: state_next = CH_IDLE;
                endcase
            end

            assign pend[gi] = (state_reg == CH_PEND);
            assign oAck[gi] = (state_reg == CH_ACK);

`ifdef HS_RR_COLLECTOR_ERR_EN
            logic err_reg;

            always_ff @(posedge iClk) begin
                if (iRst) begin
                    err_reg <= 1'b0;
                end else if ((state_reg == CH_PEND) && !grant[gi] && !iReq[gi]) begin
                    err_reg <= 1'b1;
                end
            end

            assign oErr[gi] = err_reg;
`endif
        end
    endgenerate

    assign rr_ptr_next = (grant_idx == CH_W'(CH_NUM - 1)) ? '0 : grant_idx + CH_W'(1);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rr_ptr_reg <= '0;
            valid_reg  <= 1'b0;
            data_reg   <= '0;
            ch_id_reg  <= '0;
        end else if (grant_any) begin
            rr_ptr_reg <= rr_ptr_next;
            valid_reg  <= 1'b1;
            data_reg   <= iData[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            ch_id_reg  <= grant_idx;
        end else if (iReady) begin
            // Drained with nothing to replace it; data/tag keep their last value.
            valid_reg  <= 1'b0;
        end
    end

    assign oValid = valid_reg;
    assign oData  = data_reg;
    assign oChId  = ch_id_reg;

endmodule
